// File: rtl/uart_pkg.sv
// Shared UART-side definitions: ASCII control codes, receive FSM state
// encoding and a digit classifier used by the line parsers.
package uart_pkg;

  localparam logic [7:0] CR   = 8'h0D;
  localparam logic [7:0] LF   = 8'h0A;
  localparam logic [7:0] BS   = 8'h08;
  localparam logic [7:0] DEL  = 8'h7F;
  localparam logic [7:0] ZERO = 8'h30;
  localparam logic [7:0] NINE = 8'h39;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WAITCLR = 3'd2,
    S_PARSE   = 3'd3,
    S_DONE    = 3'd4,
    S_FAIL    = 3'd5
  } rx_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ZERO) && (b <= NINE);
  endfunction

endpackage

// File: rtl/bcd_shift_buffer.sv
// Right-justified BCD digit store: push shifts a digit in at the bottom,
// pop drops the newest digit, overflow is flagged instead of corrupting data.
module bcd_shift_buffer #(
  parameter int MAXLEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [3:0]            i_digit,
  output logic [4*MAXLEN-1:0]   o_buf,
  output logic [3:0]            o_count,
  output logic                  o_ovf
);

  localparam int         W       = 4 * MAXLEN;
  localparam logic [3:0] MAX_CNT = 4'(MAXLEN);

  logic [W-1:0] r_buf;
  logic [3:0]   r_count;
  logic         r_ovf;

  // Digit storage, count and overflow flag; clear wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_buf   <= '0;
      r_count <= 4'd0;
      r_ovf   <= 1'b0;
    end else if (i_push) begin
      if (r_count < MAX_CNT) begin
        r_buf   <= (r_buf << 4) | W'(i_digit);
        r_count <= r_count + 4'd1;
      end else begin
        r_ovf   <= 1'b1;
      end
    end else if (i_pop && (r_count != 4'd0)) begin
      r_buf   <= r_buf >> 4;
      r_count <= r_count - 4'd1;
    end else begin
      r_buf   <= r_buf;
      r_count <= r_count;
      r_ovf   <= r_ovf;
    end
  end

  assign o_buf   = r_buf;
  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/passcode_rx_fsm.sv
// Drains bytes from the UART receiver with a read strobe, assembles a BCD
// passcode and reports it (or a rejected line) on carriage return.
module passcode_rx_fsm
  import uart_pkg::*;
#(
  parameter int MAXLEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rxdata,
  input  logic                rxrdy,
  output logic                rdrxd,
  output logic [4*MAXLEN-1:0] code,
  output logic [3:0]          len,
  output logic                code_valid,
  output logic                err
);

  rx_state_t           r_state;
  rx_state_t           w_next;
  logic [7:0]          r_byte;
  logic                r_bad;
  logic                w_push;
  logic                w_pop;
  logic                w_set_bad;
  logic                w_clr;
  logic [4*MAXLEN-1:0] w_buf;
  logic [3:0]          w_count;
  logic                w_ovf;
  logic                r_rdrxd;
  logic                r_code_valid;
  logic                r_err;
  logic [4*MAXLEN-1:0] r_code;
  logic [3:0]          r_len;

  bcd_shift_buffer #(.MAXLEN(MAXLEN)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_digit (r_byte[3:0]),
    .o_buf   (w_buf),
    .o_count (w_count),
    .o_ovf   (w_ovf)
  );

  assign w_clr = (r_state == S_DONE) || (r_state == S_FAIL);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-byte actions taken in PARSE.
  always_comb begin
    w_next    = r_state;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_bad = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rxrdy) begin
          w_next = S_READ;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_READ:  w_next = S_WAITCLR;
      S_WAITCLR: begin
        if (!rxrdy) begin
          w_next = S_PARSE;
        end else begin
          w_next = S_WAITCLR;
        end
      end
      S_PARSE: begin
        w_next = S_IDLE;
        if (is_digit(r_byte)) begin
          w_push = 1'b1;
        end else if ((r_byte == BS) || (r_byte == DEL)) begin
          w_pop = 1'b1;
        end else if (r_byte == LF) begin
          w_next = S_IDLE;
        end else if (r_byte == CR) begin
          // An empty clean line is silent so CR LF / LF CR give one pulse.
          if (w_ovf || r_bad) begin
            w_next = S_FAIL;
          end else if (w_count == 4'd0) begin
            w_next = S_IDLE;
          end else begin
            w_next = S_DONE;
          end
        end else begin
          w_set_bad = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_FAIL:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Byte latch and bad-character flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte <= 8'h00;
      r_bad  <= 1'b0;
    end else begin
      if (r_state == S_READ) begin
        r_byte <= rxdata;
      end else begin
        r_byte <= r_byte;
      end
      if (w_clr) begin
        r_bad <= 1'b0;
      end else if (w_set_bad) begin
        r_bad <= 1'b1;
      end else begin
        r_bad <= r_bad;
      end
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdrxd      <= 1'b0;
      r_code_valid <= 1'b0;
      r_err        <= 1'b0;
      r_code       <= '0;
      r_len        <= 4'd0;
    end else begin
      r_rdrxd      <= (w_next == S_READ);
      r_code_valid <= (w_next == S_DONE);
      r_err        <= (w_next == S_FAIL);
      if (w_next == S_DONE) begin
        r_code <= w_buf;
        r_len  <= w_count;
      end else begin
        r_code <= r_code;
        r_len  <= r_len;
      end
    end
  end

  assign rdrxd      = r_rdrxd;
  assign code_valid = r_code_valid;
  assign err        = r_err;
  assign code       = r_code;
  assign len        = r_len;

endmodule

// File: tb/tb_passcode_rx_fsm.sv
// Randomized scoreboard bench: a line-level reference model predicts every
// code_valid/err pulse; a receiver model serves bytes with random hold times.
module tb_passcode_rx_fsm;

  localparam int MAXLEN = 4;

  logic        clk;
  logic        rst;
  logic [7:0]  rxdata;
  logic        rxrdy;
  logic        rdrxd;
  logic [15:0] code;
  logic [3:0]  len;
  logic        code_valid;
  logic        err;

  passcode_rx_fsm #(.MAXLEN(MAXLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxdata     (rxdata),
    .rxrdy      (rxrdy),
    .rdrxd      (rdrxd),
    .code       (code),
    .len        (len),
    .code_valid (code_valid),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [15:0] code;
    int          len;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  byte_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_sent   = 0;
  int          n_read   = 0;
  int          hold_cnt = 0;

  // Reference model state: the line as typed so far.
  int          m_digits[$];
  bit          m_ovf;
  bit          m_bad;
  logic [15:0] m_last_code;
  int          m_last_len;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic model_reset();
    m_digits.delete();
    m_ovf = 1'b0;
    m_bad = 1'b0;
    m_last_code = 16'h0000;
    m_last_len  = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    int   v;
    if (b >= 8'h30 && b <= 8'h39) begin
      if (m_digits.size() < MAXLEN) m_digits.push_back(int'(b) - 48);
      else m_ovf = 1'b1;
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (m_digits.size() > 0) void'(m_digits.pop_back());
    end else if (b == 8'h0A) begin
      // ignored
    end else if (b == 8'h0D) begin
      if (m_ovf || m_bad) begin
        e.is_err = 1'b1; e.code = m_last_code; e.len = m_last_len;
        exp_q.push_back(e);
        m_digits.delete(); m_ovf = 1'b0; m_bad = 1'b0;
      end else if (m_digits.size() > 0) begin
        v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        e.is_err = 1'b0; e.code = 16'(v); e.len = m_digits.size();
        exp_q.push_back(e);
        m_last_code = e.code; m_last_len = e.len;
        m_digits.delete();
      end
    end else begin
      m_bad = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    byte_q.push_back(b);
    n_sent++;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((byte_q.size() != 0 || rxrdy || hold_cnt != 0) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check("drain_timeout", t < 5000, t, 5000);
    repeat (8) @(posedge clk);
  endtask

  // Receiver model: presents queued bytes, holds rxrdy a random time after rdrxd.
  initial begin
    rxrdy  = 1'b0;
    rxdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rdrxd) begin
        check("rdrxd_one_per_byte", rxrdy && hold_cnt == 0, hold_cnt, 0);
        n_read++;
        hold_cnt = 1 + $urandom_range(0, 3);
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) rxrdy = 1'b0;
      end else if (!rxrdy && byte_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        rxdata = byte_q.pop_front();
        rxrdy  = 1'b1;
      end
    end
  end

  // Monitor: every pulse must match the next predicted line result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (code_valid || err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1'b0, {code_valid, err}, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", (err == e.is_err) && (code_valid == !e.is_err),
              {code_valid, err}, {!e.is_err, e.is_err});
        check("code", code == e.code, code, e.code);
        check("len", int'(len) == e.len, len, e.len);
      end
    end
  end

  initial begin
    int r;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {rdrxd, code_valid, err, code, len} == 23'd0,
          {rdrxd, code_valid, err, code, len}, 0);
    rst = 1'b0;

    send_str("1234"); send_byte(8'h0D);
    send_str("12"); send_byte(8'h0D); send_byte(8'h0A);
    send_byte(8'h0D);
    send_str("12345"); send_byte(8'h0D);
    send_str("9"); send_byte(8'h0D);
    send_str("12"); send_byte(8'h08); send_str("5"); send_byte(8'h0D);
    send_byte(8'h7F); send_str("7"); send_byte(8'h0D);
    send_str("1a2"); send_byte(8'h0D);
    send_byte(8'h0A); send_byte(8'h0D);
    drain();

    send_str("12");
    drain();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("mid_line_reset", {rdrxd, code_valid, err, code, len} == 23'd0,
          {rdrxd, code_valid, err, code, len}, 0);
    send_str("7"); send_byte(8'h0D);
    drain();

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 58)      send_byte(8'h30 + 8'($urandom_range(0, 9)));
      else if (r < 74) send_byte(8'h0D);
      else if (r < 80) send_byte(8'h08);
      else if (r < 84) send_byte(8'h7F);
      else if (r < 91) send_byte(8'h0A);
      else             send_byte(8'($urandom_range(0, 255)));
    end
    send_byte(8'h0D);
    drain();

    check("all_pulses_seen", exp_q.size() == 0, exp_q.size(), 0);
    check("bytes_read", n_read == n_sent, n_read, n_sent);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/passcode_rx_fsm.md
Name: passcode_rx_fsm

Overview:
Receive-side companion to the UART line transmitter FSM. It drains bytes from the UART receiver one at a time using a read-strobe handshake. It assembles ASCII digits into a right-justified BCD passcode and terminates the line on carriage return. A completed code is presented to the security-system comparator with a one-cycle valid pulse; malformed lines produce a one-cycle error pulse.

Parameters:
MAXLEN, 4, maximum digits per passcode (1..8)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
rxdata  input  8  received byte from UART receiver, stable while rxrdy=1
rxrdy  input  1  receiver holds an unread byte; drops after rdrxd
rdrxd  output  1  read strobe to receiver, one-cycle pulse per byte consumed
code  output  4*MAXLEN  BCD passcode, first-typed digit most significant, right-justified
len  output  4  number of digits in code
code_valid  output  1  one-cycle pulse; code/len valid and held until next pulse
err  output  1  one-cycle pulse; line rejected, code/len unchanged

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE. rdrxd, code_valid and err are 0. code=0, len=0. Digit buffer, count, and bad/overflow flags are cleared. rst has priority over everything, including mid-line and mid-handshake.
- All outputs are registered.
- States: IDLE, READ, WAITCLR, PARSE, DONE, FAIL.
- IDLE: if rxrdy=1, go to READ; else stay.
- READ: rdrxd=1 for exactly this cycle; rxdata is latched into byte register; go to WAITCLR.
- WAITCLR: rdrxd=0; stay until rxrdy=0, then go to PARSE. This guarantees one rdrxd pulse per byte.
- PARSE: one cycle; acts on the latched byte:
  - '0'..'9' (0x30..0x39): if count<MAXLEN, buf <= {buf<<4 | byte[3:0]}, count++; else set ovf. Go to IDLE.
  - Backspace (0x08 or 0x7F): if count>0, buf <= buf>>4, count--; else no effect. Flags are unchanged. Go to IDLE.
  - LF (0x0A): ignored. Go to IDLE.
  - CR (0x0D):
    - count=0 and no flags: go to IDLE silently; no pulse.
    - ovf or bad set: go to FAIL.
    - Otherwise: go to DONE.
  - Any other byte: set bad. Go to IDLE.
- DONE: code <= buf, len <= count, code_valid=1 for this cycle. Clear buf, count and flags. Go to IDLE.
- FAIL: err=1 for this cycle. Clear buf, count and flags. code/len are not updated. Go to IDLE.
- Latency: code_valid (or err) is high in the second cycle after the cycle in which rxrdy is first seen low following the CR read (WAITCLR→PARSE→DONE).
- Throughput: a minimum of 4 cycles per byte (IDLE, READ, WAITCLR, PARSE), well under one UART frame.
- Overflow: extra digits do not corrupt buf; the whole line is rejected at CR.
- CR LF and LF CR sequences yield exactly one code_valid; the empty-line rule ensures this.
- Bytes arriving during PARSE/DONE/FAIL stay pending in the receiver and are read next in IDLE. No byte is dropped.
- rxrdy deasserting in IDLE without a read: no action.

Decomposition:
- Package uart_pkg:
  - ASCII constants: CR=8'h0D, LF=8'h0A, BS=8'h08, DEL=8'h7F, ZERO=8'h30, NINE=8'h39.
  - State enum typedef.
  - Shared with the transmitter FSMs.
- Sub-module bcd_shift_buffer (parameter MAXLEN):
  - Synchronous push/pop/clear of 4-bit digits.
  - Provides buf and count.
  - Also sets ovf on push when full.

Test Plan:
- Bytes "1234\r" → four rdrxd pulses and one code_valid; code=16'h1234, len=4, err never high.
- "12\r\n" → code=16'h0012, len=2; LF produces no second pulse. Then "\r" alone → no pulse.
- "12345\r" (MAXLEN=4) → err pulse, no code_valid; code holds its previous value. The following "9\r" → code=16'h0009.
- "12" BS "5\r" → code=16'h0015, len=2. BS on an empty line followed by "7\r" → code=16'h0007.
- "1a2\r" → err pulse; code/len unchanged.
- rst after "12", then "7\r" → code=16'h0007, len=1. Also hold rxrdy high for 3 cycles after rdrxd: the block waits in WAITCLR and consumes the byte only once.
